wb_queue: RTL and testbench
===========================

// Module: wb_queue
// PURPOSE
//   Completion queue at the tail of an execution pipe (integer or load-store).
//   Buffers retired results and drives the pipe-to-writeback valid/ready
//   interface (dst, result, pc, wb_en) toward the writeback arbiter, holding
//   entries while the arbiter favours the other pipe. Also reports pending
//   register writes so issue logic can detect RAW hazards on queued results.
// PARAMETERS
//   DEPTH  2  entry count; power of two, >= 2
//   AW     1  pointer width, = log2(DEPTH)
// PORTS
//   clk         in   1   clock
//   rst         in   1   reset, asynchronous, active-high
//   in_dst      in   5   destination register of completing instruction
//   in_result   in   64  result value
//   in_pc       in   64  instruction PC
//   in_wb_en    in   1   1 = writes rf; 0 = retire without writeback
//   in_valid    in   1   completion present
//   in_ready    out  1   queue can accept this cycle
//   wb_dst      out  5   head destination
//   wb_result   out  64  head result
//   wb_pc       out  64  head PC
//   wb_wb_en    out  1   head writeback enable
//   wb_valid    out  1   head valid
//   wb_ready    in   1   writeback accepted head this cycle
//   chk_rs1     in   5   source register to check
//   chk_rs2     in   5   source register to check
//   chk_hit1    out  1   queued entry with wb_en=1 targets chk_rs1 (rs1!=0)
//   chk_hit2    out  1   same for chk_rs2
// BEHAVIOUR
//   - Reset (async, any cycle incl. mid-transfer): rd_ptr=wr_ptr=0, count=0;
//     wb_valid=0, in_ready=1, chk_hit*=0. Storage not reset; wb_dst/result/pc/
//     wb_en undefined while wb_valid=0 and are not checked.
//   - Push: in_valid && in_ready. Pop: wb_valid && wb_ready.
//   - in_ready = (count != DEPTH); from registered count only, no combinational
//     path from wb_ready. Full queue ignores in_valid; in_valid held by source.
//   - wb_valid = (count != 0); outputs are head entry (registered storage).
//   - Latency: pushed entry visible at wb_* the cycle after push (1 cycle).
//   - Same-cycle push+pop: count unchanged, both pointers advance.
//   - Pointers AW bits, wrap DEPTH-1 -> 0; count AW+1 bits, 0..DEPTH.
//   - Entries with wb_en=0 transit like any other; ordering strictly FIFO.
//   - Once wb_valid=1, head and its fields stay stable until popped.
//   - chk_hit: OR over valid entries of (wb_en && dst==chk_rs); forced 0 when
//     chk_rs==0. Combinational; excludes current-cycle in_* input.
// CONFIGURATION
//   WB_QUEUE_BYPASS_EN defined: when count==0 and in_valid, wb_* drive in_*
//     combinationally and wb_valid=1 (0-cycle latency); if wb_ready in that
//     cycle nothing is stored, else entry written normally. in_ready unchanged.
//   Undefined: no bypass; wb_* always from storage, 1-cycle minimum latency.
// STRUCTURE
//   defines.vh: XLEN (64) and REG_IDX_W (5) constants; no new typedefs.
//   Storage, pointers and hazard compare inline; no sub-module.
// TESTING
//   1 Reset: after rst pulse -> wb_valid=0, in_ready=1, chk_hit1/2=0.
//   2 Push dst=5,res=0x1234,wb_en=1, wb_ready=0 -> next cycle wb_valid=1,
//     wb_dst=5, wb_result=0x1234; chk_rs1=5 -> chk_hit1=1; chk_rs2=0 -> 0.
//   3 DEPTH=2, wb_ready=0, push A,B -> in_ready=0; third in_valid ignored;
//     release wb_ready -> A then B in order, in_ready=1 after first pop.
//   4 Continuous push+pop with wb_ready=1 for 10 entries -> pointers wrap,
//     all 10 emerge in order, count never exceeds 1.
//   5 Entry wb_en=0 dst=7 queued -> chk_rs1=7 gives chk_hit1=0; emerges with
//     wb_wb_en=0. Async rst asserted with 2 entries -> wb_valid=0 immediately.
//   6 Bypass build: empty queue, in_valid with wb_ready=1 -> same-cycle
//     wb_valid=1, wb_dst=in_dst, count stays 0; non-bypass build -> 1 cycle.

Source files
------------

// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared constants and the RAW-hazard match helper for wb_queue.
//   XLEN      - datapath width of result/pc
//   REG_IDX_W - architectural register index width
package wb_queue_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;

  // Queued write to rs is a hazard only if the entry is live, actually
  // writes the register file, and rs is not the hardwired zero register.
  function automatic logic raw_match(input logic                 vld,
                                     input logic                 wb_en,
                                     input logic [REG_IDX_W-1:0] dst,
                                     input logic [REG_IDX_W-1:0] rs);
    return vld && wb_en && (dst == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// wb_queue_if: completion-in and writeback-out valid/ready channels.
//   in_*  : pipe completion toward the queue (in_ready flows back)
//   wb_*  : queue head toward the writeback arbiter (wb_ready flows back)
// Modports: slave = queue side, master = pipe/arbiter side.
interface wb_queue_if;
  import wb_queue_pkg::*;

  logic [REG_IDX_W-1:0] in_dst;
  logic [XLEN-1:0]      in_result;
  logic [XLEN-1:0]      in_pc;
  logic                 in_wb_en;
  logic                 in_valid;
  logic                 in_ready;

  logic [REG_IDX_W-1:0] wb_dst;
  logic [XLEN-1:0]      wb_result;
  logic [XLEN-1:0]      wb_pc;
  logic                 wb_wb_en;
  logic                 wb_valid;
  logic                 wb_ready;

  modport slave (
    input  in_dst, in_result, in_pc, in_wb_en, in_valid, wb_ready,
    output in_ready, wb_dst, wb_result, wb_pc, wb_wb_en, wb_valid
  );

  modport master (
    output in_dst, in_result, in_pc, in_wb_en, in_valid, wb_ready,
    input  in_ready, wb_dst, wb_result, wb_pc, wb_wb_en, wb_valid
  );

endinterface

// File: rtl/wb_queue.sv
// wb_queue: completion FIFO at the tail of an execution pipe. Buffers retired
// results, presents the head to the writeback arbiter, and flags queued
// register writes so issue can detect RAW hazards.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   bus (slave)       - in_* completion channel, wb_* writeback channel
//   chk_rs1/chk_rs2   - source registers to check against queued writes
//   chk_hit1/chk_hit2 - a live entry with wb_en=1 targets chk_rs (rs!=0)
// Build option: WB_QUEUE_BYPASS_EN - when empty, an incoming completion is
//   forwarded combinationally to wb_* (0-cycle latency); it is stored only
//   if the arbiter does not take it that cycle.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_queue_if.slave            bus,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  output logic                 chk_hit1,
  output logic                 chk_hit2
);

  // Storage is not reset; only pointers/count qualify it.
  logic [REG_IDX_W-1:0] r_dst [DEPTH];
  logic [XLEN-1:0]      r_res [DEPTH];
  logic [XLEN-1:0]      r_pc  [DEPTH];
  logic [DEPTH-1:0]     r_wben;

  logic [AW-1:0]        r_rd_ptr, r_wr_ptr;
  logic [AW:0]          r_count;

  logic                 w_empty, w_push, w_pop, w_wr, w_rd;
  logic [DEPTH-1:0]     w_vld, w_hit1, w_hit2;

  assign w_empty      = (r_count == '0);
  // Registered count only: no combinational path from wb_ready.
  assign bus.in_ready = (r_count != (AW+1)'(DEPTH));
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = bus.wb_valid && bus.wb_ready;

`ifdef WB_QUEUE_BYPASS_EN
  logic w_byp;
  assign w_byp         = w_empty && bus.in_valid;
  assign bus.wb_valid  = !w_empty || bus.in_valid;
  assign bus.wb_dst    = w_byp ? bus.in_dst    : r_dst[r_rd_ptr];
  assign bus.wb_result = w_byp ? bus.in_result : r_res[r_rd_ptr];
  assign bus.wb_pc     = w_byp ? bus.in_pc     : r_pc[r_rd_ptr];
  assign bus.wb_wb_en  = w_byp ? bus.in_wb_en  : r_wben[r_rd_ptr];
  // A bypassed entry consumed in the same cycle never touches storage.
  assign w_wr          = w_push && !(w_byp && bus.wb_ready);
  assign w_rd          = w_pop && !w_byp;
`else
  assign bus.wb_valid  = !w_empty;
  assign bus.wb_dst    = r_dst[r_rd_ptr];
  assign bus.wb_result = r_res[r_rd_ptr];
  assign bus.wb_pc     = r_pc[r_rd_ptr];
  assign bus.wb_wb_en  = r_wben[r_rd_ptr];
  assign w_wr          = w_push;
  assign w_rd          = w_pop;
`endif

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_dst[r_wr_ptr]  <= bus.in_dst;
      r_res[r_wr_ptr]  <= bus.in_result;
      r_pc[r_wr_ptr]   <= bus.in_pc;
      r_wben[r_wr_ptr] <= bus.in_wb_en;
    end
  end

  // DEPTH is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Slot g is live when its distance from the head is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [AW-1:0] w_off;
    assign w_off     = AW'(g) - r_rd_ptr;
    assign w_vld[g]  = ({1'b0, w_off} < r_count);
    assign w_hit1[g] = raw_match(w_vld[g], r_wben[g], r_dst[g], chk_rs1);
    assign w_hit2[g] = raw_match(w_vld[g], r_wben[g], r_dst[g], chk_rs2);
  end

  assign chk_hit1 = |w_hit1;
  assign chk_hit2 = |w_hit2;

endmodule

// File: tb/tb_wb_queue.sv
`timescale 1ns/1ps
module tb_wb_queue;
  import wb_queue_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] res;
    logic [63:0] pc;
    logic        wben;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_queue_if bus();
  logic [4:0] chk_rs1 = '0, chk_rs2 = '0;
  logic       chk_hit1, chk_hit2;

  wb_queue #(.DEPTH(DEPTH), .AW(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .chk_rs1  (chk_rs1),
    .chk_rs2  (chk_rs2),
    .chk_hit1 (chk_hit1),
    .chk_hit2 (chk_hit2)
  );

  ent_t sb[$];
  int   n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, obs, exp);
  endtask

  function automatic logic mhit(input logic [4:0] rs);
    if (rs == '0) return 1'b0;
    foreach (sb[i]) if (sb[i].wben && sb[i].dst == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ent_t mk(input logic [4:0] d, input logic [63:0] r, input logic w);
    ent_t e;
    e.dst = d; e.res = r; e.pc = 64'h8000_0000 + {r[31:0], 2'b00}; e.wben = w;
    return e;
  endfunction

  // One clock: drive at negedge, sample 1ns later, update scoreboard for the
  // transfers that the coming posedge will perform.
  task automatic cyc(input logic v, input ent_t e, input logic rdy);
    logic exp_v;
    ent_t f;
    @(negedge clk);
    bus.in_valid = v; bus.in_dst = e.dst; bus.in_result = e.res;
    bus.in_pc = e.pc; bus.in_wb_en = e.wben; bus.wb_ready = rdy;
    #1;
    exp_v = (sb.size() != 0);
`ifdef WB_QUEUE_BYPASS_EN
    if (sb.size() == 0 && v) exp_v = 1'b1;
`endif
    check("in_ready", 64'(bus.in_ready), 64'(sb.size() != DEPTH));
    check("wb_valid", 64'(bus.wb_valid), 64'(exp_v));
    check("chk_hit1", 64'(chk_hit1), 64'(mhit(chk_rs1)));
    check("chk_hit2", 64'(chk_hit2), 64'(mhit(chk_rs2)));
    if (sb.size() != 0) check("head_dst", 64'(bus.wb_dst), 64'(sb[0].dst));
    if (v && bus.in_ready) sb.push_back(e);
    if (bus.wb_valid && rdy) begin
      if (sb.size() == 0) check("underflow", 64'd1, 64'd0);
      else begin
        f = sb.pop_front();
        check("pop_dst",  64'(bus.wb_dst), 64'(f.dst));
        check("pop_res",  bus.wb_result,   f.res);
        check("pop_pc",   bus.wb_pc,       f.pc);
        check("pop_wben", 64'(bus.wb_wb_en), 64'(f.wben));
      end
    end
  endtask

  ent_t z;

  initial begin
    z = mk(5'd0, 64'd0, 1'b0);
    bus.in_valid = 1'b0; bus.in_dst = '0; bus.in_result = '0; bus.in_pc = '0;
    bus.in_wb_en = 1'b0; bus.wb_ready = 1'b0;

    // 1 reset
    repeat (2) @(negedge clk);
    #1;
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_hit1", 64'(chk_hit1), 64'd0);
    check("rst_hit2", 64'(chk_hit2), 64'd0);
    rst = 1'b0;

    // 2 single push, hazard visible once queued
    chk_rs1 = 5'd5; chk_rs2 = 5'd0;
    cyc(1'b1, mk(5'd5, 64'h1234, 1'b1), 1'b0);
    cyc(1'b0, z, 1'b0);
    check("t2_hit1", 64'(chk_hit1), 64'd1);
    check("t2_res", bus.wb_result, 64'h1234);
    cyc(1'b0, z, 1'b1);

    // 3 fill, overflow attempt, ordered drain
    cyc(1'b1, mk(5'd10, 64'hA, 1'b1), 1'b0);
    cyc(1'b1, mk(5'd11, 64'hB, 1'b1), 1'b0);
    cyc(1'b1, mk(5'd12, 64'hC, 1'b1), 1'b0);
    check("t3_full", 64'(sb.size()), 64'd2);
    cyc(1'b1, mk(5'd12, 64'hC, 1'b1), 1'b1);
    cyc(1'b1, mk(5'd12, 64'hC, 1'b1), 1'b1);
    cyc(1'b0, z, 1'b1);

    // 4 streaming push+pop, pointers wrap
    for (int i = 0; i < 10; i++) begin
      chk_rs1 = 5'(i + 1); chk_rs2 = 5'($urandom_range(0, 31));
      cyc(1'b1, mk(5'(i + 1), {32'd0, $urandom}, 1'(i % 3 != 0)), 1'b1);
    end
    cyc(1'b0, z, 1'b1);
    cyc(1'b0, z, 1'b1);

    // 5 wb_en=0 entry is not a hazard and emerges with wb_en=0
    chk_rs1 = 5'd7; chk_rs2 = 5'd9;
    cyc(1'b1, mk(5'd7, 64'h77, 1'b0), 1'b0);
    cyc(1'b0, z, 1'b0);
    check("t5_hit1", 64'(chk_hit1), 64'd0);
    cyc(1'b0, z, 1'b1);

    // 5b async reset while holding two entries
    cyc(1'b1, mk(5'd9, 64'h99, 1'b1), 1'b0);
    cyc(1'b1, mk(5'd3, 64'h33, 1'b1), 1'b0);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    check("pre_rst_hit2", 64'(chk_hit2), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_hit2", 64'(chk_hit2), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    // 6 empty queue, push with wb_ready=1 (bypass vs 1-cycle latency)
    chk_rs1 = 5'd21;
    cyc(1'b1, mk(5'd21, 64'hBEEF, 1'b1), 1'b1);
    cyc(1'b0, z, 1'b1);
    cyc(1'b0, z, 1'b1);
    check("t6_empty", 64'(bus.wb_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
